// File: rtl/div_issue_ctrl_if.sv
// Request, divider and result signals of div_issue_ctrl grouped as one bundle.
// The slave view is the controller; the master view is its environment.
interface div_issue_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     in_dividend;
    logic [WIDTH-1:0]       in_divisor;
    logic                   div_din_valid;
    logic [2*WIDTH-1:0]     div_dividend;
    logic [WIDTH-1:0]       div_divisor;
    logic [2*WIDTH-1:0]     div_quotient;
    logic [WIDTH-1:0]       div_remainder;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_quotient;
    logic [WIDTH-1:0]       out_remainder;
    logic                   out_div_by_zero;
    logic                   busy;

    modport slave (
        input  in_valid, in_dividend, in_divisor,
        input  div_quotient, div_remainder,
        input  out_ready,
        output in_ready, div_din_valid, div_dividend, div_divisor,
        output out_valid, out_quotient, out_remainder, out_div_by_zero, busy
    );

    modport master (
        output in_valid, in_dividend, in_divisor,
        output div_quotient, div_remainder,
        output out_ready,
        input  in_ready, div_din_valid, div_dividend, div_divisor,
        input  out_valid, out_quotient, out_remainder, out_div_by_zero, busy
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Front-end for the multi-cycle restoring divider: accepts one request, filters
// divide-by-zero, pulses start, waits LATENCY cycles and holds the result.
module div_issue_ctrl #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst,
    div_issue_ctrl_if.slave   bus
);
    localparam int         QW    = 2 * WIDTH;
    localparam logic [7:0] LAT_C = 8'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_next_s;
    logic              accept_s;
    logic              zero_div_s;
    logic              capture_s;
    logic              release_s;

    logic              in_ready_r;
    logic              busy_r;
    logic              din_valid_r;
    logic [QW-1:0]     dividend_r;
    logic [WIDTH-1:0]  divisor_r;
    logic              out_valid_r;
    logic [QW-1:0]     quotient_r;
    logic [WIDTH-1:0]  remainder_r;
    logic              dbz_r;

    // Next-state and event decode for the issue/wait/hold sequence
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        zero_div_s   = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    if (bus.in_divisor == {WIDTH{1'b0}}) begin
                        zero_div_s   = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_next_s   = LAT_C;
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // The edge seeing cnt_r == 1 is the one where divider outputs are final
                if (cnt_r == 8'd1) begin
                    capture_s    = 1'b1;
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                cnt_next_s   = 8'd0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered handshake flags, divider operands and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            din_valid_r <= 1'b0;
            dividend_r  <= {QW{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            quotient_r  <= {QW{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            din_valid_r <= (state_next_s == ST_ISSUE);
            if (accept_s) begin
                dividend_r <= bus.in_dividend;
                divisor_r  <= bus.in_divisor;
            end
            if (zero_div_s) begin
                quotient_r  <= {QW{1'b1}};
                remainder_r <= bus.in_dividend[WIDTH-1:0];
                dbz_r       <= 1'b1;
                out_valid_r <= 1'b1;
            end else if (capture_s) begin
                quotient_r  <= bus.div_quotient;
                remainder_r <= bus.div_remainder;
                dbz_r       <= 1'b0;
                out_valid_r <= 1'b1;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready        = in_ready_r;
    assign bus.busy            = busy_r;
    assign bus.div_din_valid   = din_valid_r;
    assign bus.div_dividend    = dividend_r;
    assign bus.div_divisor     = divisor_r;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_quotient    = quotient_r;
    assign bus.out_remainder   = remainder_r;
    assign bus.out_div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that presents
// the true result only in the cycle before the capture edge.
module tb_div_issue_ctrl;
    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;

    int         m_cnt = 0;
    logic [7:0] m_q = 8'h00;
    logic [3:0] m_r = 4'h0;

    div_issue_ctrl_if #(.WIDTH(4)) bus ();

    div_issue_ctrl #(.WIDTH(4), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Divider model: samples start, counts down to the capture edge
    always @(posedge clk) begin
        if (bus.div_din_valid) begin
            m_cnt <= LAT;
            m_q   <= bus.div_dividend / {4'h0, bus.div_divisor};
            m_r   <= 4'(bus.div_dividend % {4'h0, bus.div_divisor});
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Correct result only right before the capture edge, inverted garbage otherwise
    always @(negedge clk) begin
        if (m_cnt == 1) begin
            bus.div_quotient  <= m_q;
            bus.div_remainder <= m_r;
        end else begin
            bus.div_quotient  <= ~m_q;
            bus.div_remainder <= ~m_r;
        end
        if (bus.div_din_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", bus.out_valid); end
        checks++; if (bus.div_din_valid !== 1'b0) begin errors++; $display("FAIL reset_din_valid got %0h exp 0", bus.div_din_valid); end
        checks++; if ({bus.out_quotient, bus.out_remainder, bus.out_div_by_zero} !== 13'h0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", {bus.out_quotient, bus.out_remainder, bus.out_div_by_zero}); end
        checks++; if ({bus.div_dividend, bus.div_divisor} !== 12'h0) begin errors++; $display("FAIL reset_operands got %0h exp 0", {bus.div_dividend, bus.div_divisor}); end
    endtask

    task automatic test_normal();
        int p0;
        bit early;
        p0 = pulse_cnt;
        early = 1'b0;
        bus.in_dividend = 8'd100;
        bus.in_divisor  = 4'd7;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.div_din_valid !== 1'b1) begin errors++; $display("FAIL normal_start got %0h exp 1", bus.div_din_valid); end
        checks++; if (bus.div_dividend !== 8'd100 || bus.div_divisor !== 4'd7) begin errors++; $display("FAIL normal_operands got %0d/%0d exp 100/7", bus.div_dividend, bus.div_divisor); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL normal_busy got rdy %0h busy %0h exp 0/1", bus.in_ready, bus.busy); end
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.div_din_valid !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin errors++; $display("FAIL normal_early got early valid/start exp none"); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL normal_latency got out_valid %0h exp 1 at edge 11", bus.out_valid); end
        checks++; if (bus.out_quotient !== 8'd14 || bus.out_remainder !== 4'd2 || bus.out_div_by_zero !== 1'b0) begin errors++; $display("FAIL normal_result got %0d r %0d z %0h exp 14 r 2 z 0", bus.out_quotient, bus.out_remainder, bus.out_div_by_zero); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL normal_pulses got %0d exp 1", pulse_cnt - p0); end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL normal_release got v %0h rdy %0h exp 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_zero_div();
        int p0;
        p0 = pulse_cnt;
        bus.in_dividend = 8'hA5;
        bus.in_divisor  = 4'h0;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0h exp 1", bus.out_valid); end
        checks++; if (bus.out_quotient !== 8'hFF || bus.out_remainder !== 4'h5 || bus.out_div_by_zero !== 1'b1) begin errors++; $display("FAIL zero_result got %0h r %0h z %0h exp ff r 5 z 1", bus.out_quotient, bus.out_remainder, bus.out_div_by_zero); end
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_quotient !== 8'hFF) begin errors++; $display("FAIL zero_hold got v %0h q %0h exp 1 ff", bus.out_valid, bus.out_quotient); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL zero_no_pulse got %0d exp 0", pulse_cnt - p0); end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_release got v %0h busy %0h exp 0/0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_backpressure();
        int n;
        bit bad;
        bad = 1'b0;
        bus.in_dividend = 8'd60;
        bus.in_divisor  = 4'd4;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_dividend = 8'd50;
        bus.in_divisor  = 4'd3;
        wait_result(n);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_quotient !== 8'd15 || bus.out_remainder !== 4'd0) begin errors++; $display("FAIL bp_first got v %0h q %0d r %0d exp 1 15 0", bus.out_valid, bus.out_quotient, bus.out_remainder); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_quotient !== 8'd15 || bus.out_remainder !== 4'd0 ||
                bus.in_ready !== 1'b0 || bus.div_dividend !== 8'd60) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold got unstable output or new latch exp stable 15/0 dividend 60"); end
        handshake();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_dividend !== 8'd60) begin errors++; $display("FAIL bp_idle got rdy %0h v %0h dvd %0d exp 1 0 60", bus.in_ready, bus.out_valid, bus.div_dividend); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.div_dividend !== 8'd50 || bus.div_divisor !== 4'd3 || bus.div_din_valid !== 1'b1) begin errors++; $display("FAIL bp_accept got %0d/%0d start %0h exp 50/3 1", bus.div_dividend, bus.div_divisor, bus.div_din_valid); end
        wait_result(n);
        checks++; if (n !== LAT + 1) begin errors++; $display("FAIL bp_latency got %0d exp %0d", n, LAT + 1); end
        checks++; if (bus.out_quotient !== 8'd16 || bus.out_remainder !== 4'd2) begin errors++; $display("FAIL bp_result got %0d r %0d exp 16 r 2", bus.out_quotient, bus.out_remainder); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int p0;
        bit bad;
        bad = 1'b0;
        bus.in_dividend = 8'd100;
        bus.in_divisor  = 4'd7;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got busy %0h exp 1", bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p0 = pulse_cnt;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.div_din_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy %0h v %0h rdy %0h st %0h exp 0 0 1 0", bus.busy, bus.out_valid, bus.in_ready, bus.div_din_valid); end
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.out_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad || pulse_cnt - p0 !== 0) begin errors++; $display("FAIL rstmid_quiet got result or %0d pulses exp none", pulse_cnt - p0); end
    endtask

    task automatic test_capture_window();
        int n;
        bus.in_dividend = 8'd19;
        bus.in_divisor  = 4'd2;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_result(n);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_quotient !== 8'd9 || bus.out_remainder !== 4'd1) begin errors++; $display("FAIL capture_value got v %0h q %0d r %0d exp 1 9 1", bus.out_valid, bus.out_quotient, bus.out_remainder); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (bus.out_quotient !== 8'd9 || bus.out_remainder !== 4'd1) begin errors++; $display("FAIL capture_hold got q %0d r %0d exp 9 1", bus.out_quotient, bus.out_remainder); end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [7:0] dvd [3] = '{8'd200, 8'd255, 8'd7};
        logic [3:0] dvs [3] = '{4'd13, 4'd1, 4'd8};
        logic [7:0] exq [3] = '{8'd15, 8'd255, 8'd0};
        logic [3:0] exr [3] = '{4'd5, 4'd0, 4'd7};
        logic [7:0] gq [3];
        logic [3:0] gr [3];
        logic       gz [3];
        int acc [3];
        int idx;
        int nres;
        bit acc_now;
        idx  = 0;
        nres = 0;
        bus.out_ready   = 1'b1;
        bus.in_dividend = dvd[0];
        bus.in_divisor  = dvs[0];
        bus.in_valid    = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (bus.out_valid === 1'b1 && nres < 3) begin
                gq[nres] = bus.out_quotient;
                gr[nres] = bus.out_remainder;
                gz[nres] = bus.out_div_by_zero;
                nres++;
            end
            acc_now = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
            if (acc_now) acc[idx] = cyc;
            tick();
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    bus.in_dividend = dvd[idx];
                    bus.in_divisor  = dvs[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        checks++; if (nres !== 3 || idx !== 3) begin errors++; $display("FAIL b2b_count got %0d results %0d accepts exp 3 3", nres, idx); end
        for (int i = 0; i < 3; i++) begin
            if (i < nres) begin
                checks++; if (gq[i] !== exq[i] || gr[i] !== exr[i] || gz[i] !== 1'b0) begin errors++; $display("FAIL b2b_result%0d got %0d r %0d z %0h exp %0d r %0d z 0", i, gq[i], gr[i], gz[i], exq[i], exr[i]); end
            end
        end
        if (idx == 3) begin
            checks++; if (acc[1] - acc[0] !== LAT + 3 || acc[2] - acc[1] !== LAT + 3) begin errors++; $display("FAIL b2b_spacing got %0d,%0d exp %0d", acc[1] - acc[0], acc[2] - acc[1], LAT + 3); end
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_dividend = 8'h00;
        bus.in_divisor  = 4'h0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_normal();
        test_zero_div();
        test_backpressure();
        test_reset_mid();
        test_capture_window();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
